// File: rtl/lcd_en_gen.sv
// LCD E-strobe generator: programmable setup / high / hold phases with a
// mid-high sample strobe, single-shot handshake, continuous mode and long hold.
module lcd_en_gen #(
    parameter int unsigned CNT_W         = 17,
    parameter int unsigned SETUP_CYC     = 2000,
    parameter int unsigned HIGH_CYC      = 25000,
    parameter int unsigned MID_IDX       = 12500,
    parameter int unsigned HOLD_CYC      = 100000,
    parameter int unsigned HOLD_LONG_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cont_mode,
    input  logic long_hold,
    output logic en,
    output logic in_mid_high,
    output logic busy,
    output logic done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [CNT_W-1:0] SETUP_LAST     = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST      = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST      = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LONG_LAST = CNT_W'(HOLD_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] MID_VAL        = CNT_W'(MID_IDX);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold_sel;
    logic             r_en;
    logic             r_mid;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_hold_sel_nx;
    logic             w_done_nx;
    logic             w_last;

    // Next-state and phase counter; counter restarts at every phase entry
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt + CNT_W'(1);
        w_hold_sel_nx = r_hold_sel;
        w_done_nx     = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (start) begin
                    w_state_nx    = S_SETUP;
                    w_hold_sel_nx = long_hold;
                end
            end
            S_SETUP: begin
                w_last = (r_cnt == SETUP_LAST);
                if (w_last) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = '0;
                end
            end
            S_HIGH: begin
                w_last = (r_cnt == HIGH_LAST);
                if (w_last) begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = '0;
                end
            end
            S_HOLD: begin
                w_last = r_hold_sel ? (r_cnt == HOLD_LONG_LAST) : (r_cnt == HOLD_LAST);
                if (w_last) begin
                    w_cnt_nx = '0;
                    if (cont_mode) begin
                        w_state_nx    = S_SETUP;
                        w_hold_sel_nx = long_hold;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hold_sel <= 1'b0;
            r_en       <= 1'b0;
            r_mid      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_hold_sel <= w_hold_sel_nx;
            r_en       <= (w_state_nx == S_HIGH);
            r_mid      <= (w_state_nx == S_HIGH) && (w_cnt_nx == MID_VAL);
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= w_done_nx;
        end
    end

    assign en          = r_en;
    assign in_mid_high = r_mid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
